// File: rtl/fetch_pkg.sv
// Shared types and default sizing for the instruction fetch stage.
package fetch_pkg;

  localparam int FETCH_DEPTH  = 2;
  localparam int FETCH_ADDR_W = 32;
  localparam int FETCH_DATA_W = 32;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_DISCARD = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [FETCH_ADDR_W-1:0] pc;
    logic [FETCH_DATA_W-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding fetched {pc, inst} pairs; flush empties it in one edge.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk_i,
  input  logic             nrst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] entry_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [CNT_W-1:0] count_o,
  output logic [WIDTH-1:0] head_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_en, pop_en;

  assign push_en = push_i & ~flush_i;
  assign pop_en  = pop_i & ~flush_i & (count_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_en)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push_en, pop_en})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately not reset; count gates every read of it.
  always_ff @(posedge clk_i) begin
    if (push_en) mem_q[wr_ptr_q] <= entry_i;
  end

  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: one outstanding imem read, results queued for decode, PC stall and redirect.
//   state     | meaning
//   S_IDLE    | no request outstanding, may issue
//   S_WAIT    | request outstanding, data will be queued
//   S_DISCARD | request outstanding after redirect, data will be dropped
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int DEPTH  = FETCH_DEPTH,
  parameter int ADDR_W = FETCH_ADDR_W,
  parameter int DATA_W = FETCH_DATA_W
) (
  input  logic              clk_i,
  input  logic              nrst_i,
  input  logic [ADDR_W-1:0] pc_i,
  output logic              pc_stall_o,
  input  logic              redirect_i,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic              imem_ack_i,
  input  logic [DATA_W-1:0] imem_data_i,
  output logic              inst_valid_o,
  output logic [DATA_W-1:0] inst_o,
  output logic [ADDR_W-1:0] inst_pc_o,
  input  logic              inst_ready_i
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int ENT_W = ADDR_W + DATA_W;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  fetch_state_e      state_q, state_d;
  logic              req_q, req_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              issue, push, pop;
  logic [CNT_W-1:0]  count;
  logic [ENT_W-1:0]  head;

  // nrst_i is in the issue term so the PC holds while reset is asserted.
  assign issue = (state_q == S_IDLE) & nrst_i & ~redirect_i & (count < DEPTH_C);

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    addr_d  = addr_q;
    push    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (issue) begin
          req_d   = 1'b1;
          addr_d  = pc_i;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_ack_i) begin
          push    = ~redirect_i;
          req_d   = 1'b0;
          state_d = S_IDLE;
        end else if (redirect_i) begin
          state_d = S_DISCARD;
        end
      end
      S_DISCARD: begin
        if (imem_ack_i) begin
          req_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        req_d   = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      state_q <= S_IDLE;
      req_q   <= 1'b0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
    end
  end

  assign pop = inst_valid_o & inst_ready_i;

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENT_W)
  ) u_fifo (
    .clk_i   (clk_i),
    .nrst_i  (nrst_i),
    .push_i  (push),
    .entry_i ({addr_q, imem_data_i}),
    .pop_i   (pop),
    .flush_i (redirect_i),
    .count_o (count),
    .head_o  (head)
  );

  assign pc_stall_o   = ~issue;
  assign imem_req_o   = req_q;
  assign imem_addr_o  = addr_q;
  assign inst_valid_o = (count != '0);
  assign inst_o       = head[DATA_W-1:0];
  assign inst_pc_o    = head[ENT_W-1:DATA_W];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed, table-driven bench for instr_fetch_unit with hand-computed per-cycle expectations.
module tb_instr_fetch_unit;
  import fetch_pkg::*;

  logic        clk_i = 1'b0;
  logic        nrst_i;
  logic [31:0] pc_i;
  logic        pc_stall_o;
  logic        redirect_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i;
  logic [31:0] imem_data_i;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic        inst_ready_i;

  instr_fetch_unit #(.DEPTH(2), .ADDR_W(32), .DATA_W(32)) dut (
    .clk_i        (clk_i),
    .nrst_i       (nrst_i),
    .pc_i         (pc_i),
    .pc_stall_o   (pc_stall_o),
    .redirect_i   (redirect_i),
    .imem_req_o   (imem_req_o),
    .imem_addr_o  (imem_addr_o),
    .imem_ack_i   (imem_ack_i),
    .imem_data_i  (imem_data_i),
    .inst_valid_o (inst_valid_o),
    .inst_o       (inst_o),
    .inst_pc_o    (inst_pc_o),
    .inst_ready_i (inst_ready_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0]  pc;
    logic         redir;
    logic         ack;
    logic [31:0]  data;
    logic         ready;
    logic         e_stall;
    logic         e_req;
    logic [31:0]  e_addr;
    logic         e_valid;
    fetch_entry_t e_head;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_err = 0;

  localparam logic [31:0] IB  = 32'h1000_0000;
  localparam logic [31:0] BAD = 32'hDEAD_BEEF;

  task automatic add(input logic [31:0] pc, input logic rd, input logic ack,
                     input logic [31:0] data, input logic rdy, input logic st,
                     input logic rq, input logic [31:0] ad, input logic vl,
                     input logic [31:0] hpc, input logic [31:0] hin);
    vec_t v;
    v.pc = pc; v.redir = rd; v.ack = ack; v.data = data; v.ready = rdy;
    v.e_stall = st; v.e_req = rq; v.e_addr = ad; v.e_valid = vl;
    v.e_head.pc = hpc; v.e_head.inst = hin;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s (step %0d): got %h, expected %h", name, idx, act, exp);
    end
  endtask

  task automatic check_outs(input int idx, input logic st, input logic rq,
                            input logic [31:0] ad, input logic vl,
                            input fetch_entry_t hd);
    n_vec++;
    chk("pc_stall_o", idx, {31'b0, pc_stall_o}, {31'b0, st});
    chk("imem_req_o", idx, {31'b0, imem_req_o}, {31'b0, rq});
    chk("imem_addr_o", idx, imem_addr_o, ad);
    chk("inst_valid_o", idx, {31'b0, inst_valid_o}, {31'b0, vl});
    if (vl) begin
      chk("inst_pc_o", idx, inst_pc_o, hd.pc);
      chk("inst_o", idx, inst_o, hd.inst);
    end
  endtask

  initial begin
    fetch_entry_t none;
    fetch_entry_t h;
    none = '0;

    // pc, redir, ack, data, ready | stall, req, addr, valid, head pc, head inst
    // back-to-back fetches with zero-wait memory
    add(32'h00, 0, 0, 0,          1, 0, 0, 32'h00, 0, 0,     0);
    add(32'h04, 0, 1, IB+32'h00,  1, 1, 1, 32'h00, 0, 0,     0);
    add(32'h04, 0, 0, 0,          1, 0, 0, 32'h00, 1, 32'h00, IB+32'h00);
    add(32'h08, 0, 1, IB+32'h04,  1, 1, 1, 32'h04, 0, 0,     0);
    add(32'h08, 0, 0, 0,          1, 0, 0, 32'h04, 1, 32'h04, IB+32'h04);
    add(32'h0C, 0, 1, IB+32'h08,  1, 1, 1, 32'h08, 0, 0,     0);
    // decode stalls: queue fills, issue blocked, one pop frees one issue
    add(32'h0C, 0, 0, 0,          0, 0, 0, 32'h08, 1, 32'h08, IB+32'h08);
    add(32'h10, 0, 1, IB+32'h0C,  0, 1, 1, 32'h0C, 1, 32'h08, IB+32'h08);
    add(32'h10, 0, 0, 0,          0, 1, 0, 32'h0C, 1, 32'h08, IB+32'h08);
    add(32'h10, 0, 0, 0,          0, 1, 0, 32'h0C, 1, 32'h08, IB+32'h08);
    add(32'h10, 0, 0, 0,          1, 1, 0, 32'h0C, 1, 32'h08, IB+32'h08);
    add(32'h10, 0, 0, 0,          0, 0, 0, 32'h0C, 1, 32'h0C, IB+32'h0C);
    // three-cycle memory wait, request held
    add(32'h14, 0, 0, 0,          0, 1, 1, 32'h10, 1, 32'h0C, IB+32'h0C);
    add(32'h14, 0, 0, 0,          0, 1, 1, 32'h10, 1, 32'h0C, IB+32'h0C);
    add(32'h14, 0, 0, 0,          0, 1, 1, 32'h10, 1, 32'h0C, IB+32'h0C);
    add(32'h14, 0, 1, IB+32'h10,  0, 1, 1, 32'h10, 1, 32'h0C, IB+32'h0C);
    add(32'h14, 0, 0, 0,          1, 1, 0, 32'h10, 1, 32'h0C, IB+32'h0C);
    add(32'h14, 0, 0, 0,          1, 0, 0, 32'h10, 1, 32'h10, IB+32'h10);
    add(32'h18, 0, 0, 0,          1, 1, 1, 32'h14, 0, 0,     0);
    // redirect while waiting: discard the late data, restart at 0x40
    add(32'h40, 1, 0, 0,          1, 1, 1, 32'h14, 0, 0,     0);
    add(32'h40, 0, 0, 0,          1, 1, 1, 32'h14, 0, 0,     0);
    add(32'h40, 0, 1, BAD,        1, 1, 1, 32'h14, 0, 0,     0);
    add(32'h40, 0, 0, 0,          1, 0, 0, 32'h14, 0, 0,     0);
    add(32'h44, 0, 1, IB+32'h40,  1, 1, 1, 32'h40, 0, 0,     0);
    add(32'h44, 0, 0, 0,          1, 0, 0, 32'h40, 1, 32'h40, IB+32'h40);
    // redirect coincident with ack
    add(32'h48, 1, 1, BAD,        1, 1, 1, 32'h44, 0, 0,     0);
    add(32'h80, 0, 0, 0,          0, 0, 0, 32'h44, 0, 0,     0);
    add(32'h84, 0, 1, IB+32'h80,  0, 1, 1, 32'h80, 0, 0,     0);
    add(32'h84, 0, 0, 0,          0, 0, 0, 32'h80, 1, 32'h80, IB+32'h80);
    add(32'h88, 0, 1, IB+32'h84,  0, 1, 1, 32'h84, 1, 32'h80, IB+32'h80);
    // redirect coincident with pop on a full queue
    add(32'h88, 1, 0, 0,          1, 1, 0, 32'h84, 1, 32'h80, IB+32'h80);
    add(32'hC0, 0, 0, 0,          1, 0, 0, 32'h84, 0, 0,     0);
    add(32'hC4, 0, 0, 0,          1, 1, 1, 32'hC0, 0, 0,     0);

    nrst_i = 1'b0; pc_i = '0; redirect_i = 1'b0; imem_ack_i = 1'b0;
    imem_data_i = '0; inst_ready_i = 1'b0;
    #1;
    check_outs(-1, 1'b1, 1'b0, 32'h0, 1'b0, none);
    @(negedge clk_i);
    @(negedge clk_i);
    nrst_i = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      pc_i         = vecs[i].pc;
      redirect_i   = vecs[i].redir;
      imem_ack_i   = vecs[i].ack;
      imem_data_i  = vecs[i].data;
      inst_ready_i = vecs[i].ready;
      #1;
      h = vecs[i].e_head;
      check_outs(i, vecs[i].e_stall, vecs[i].e_req, vecs[i].e_addr, vecs[i].e_valid, h);
      @(negedge clk_i);
    end

    // async reset while a request is outstanding
    pc_i = 32'hC4; redirect_i = 1'b0; imem_ack_i = 1'b0; inst_ready_i = 1'b0;
    #1;
    check_outs(100, 1'b1, 1'b1, 32'hC0, 1'b0, none);
    #1;
    nrst_i = 1'b0;
    #1;
    check_outs(101, 1'b1, 1'b0, 32'h0, 1'b0, none);
    @(negedge clk_i);
    nrst_i = 1'b1;
    pc_i   = 32'h100;
    #1;
    check_outs(102, 1'b0, 1'b0, 32'h0, 1'b0, none);
    @(posedge clk_i);
    #1;
    pc_i = 32'h104;
    #1;
    check_outs(103, 1'b1, 1'b1, 32'h100, 1'b0, none);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Fetch stage sitting directly downstream of the program counter register. It takes the current PC and issues one instruction-memory read at a time over a req/ack handshake. Returned instructions and their PCs are buffered in a small queue for the decode stage. The unit drives a stall back to the next-PC mux so the PC only advances when a fetch is actually issued, and it supports a flush/redirect for taken branches and jumps.

## Interface
- DEPTH, 2: instruction-queue entries; power of two, ≥2
- ADDR_W, 32: PC / memory address width
- DATA_W, 32: instruction width
- clk_i  in  1  single clock, rising edge
- nrst_i  in  1  asynchronous, active-low reset
- pc_i  in  ADDR_W  current PC from the program counter register
- pc_stall_o  out  1  1 = next-PC mux must reload the current PC (hold); 0 = PC may advance
- redirect_i  in  1  taken branch/jump: flush queue, drop in-flight fetch; next-PC mux loads the target with priority over pc_stall_o
- imem_req_o  out  1  read request; registered, held high until ack
- imem_addr_o  out  ADDR_W  read address, stable while imem_req_o=1
- imem_ack_i  in  1  read data valid; only meaningful while imem_req_o=1
- imem_data_i  in  DATA_W  read data, sampled with imem_ack_i
- inst_valid_o  out  1  queue head valid
- inst_o  out  DATA_W  queue head instruction
- inst_pc_o  out  ADDR_W  PC of queue head
- inst_ready_i  in  1  decode accepts head when inst_valid_o & inst_ready_i

## Operation
- FSM states: IDLE, WAIT, DISCARD. At most one memory request is outstanding.
- Issue condition is IDLE & nrst_i & ~redirect_i & (count < DEPTH). On issue:
  - imem_addr_o <= pc_i, imem_req_o <= 1, next state WAIT.
  - pc_stall_o = ~issue (combinational), so the PC advances exactly once per issued fetch.
- WAIT & imem_ack_i & ~redirect_i: push {imem_addr_o, imem_data_i}, imem_req_o <= 0, next state IDLE.
- WAIT & redirect_i & ~imem_ack_i: next state DISCARD; imem_req_o stays high until ack.
- WAIT & redirect_i & imem_ack_i: drop the data, imem_req_o <= 0, next state IDLE.
- DISCARD & imem_ack_i: drop the data, imem_req_o <= 0, next state IDLE. No issue occurs in the same cycle.
- Queue behaviour:
  - inst_valid_o = (count != 0); inst_o and inst_pc_o are the head entry.
  - Pop on inst_valid_o & inst_ready_i. Push and pop in the same cycle leave count unchanged.
  - Count ranges 0..DEPTH.
  - Pointers wrap modulo DEPTH; the count register is log2(DEPTH)+1 bits wide.
- redirect_i clears the queue (count, pointers = 0) at the next edge. A pop or push in that same cycle is ignored.
- Reset (async, nrst_i=0) sets:
  - state IDLE, imem_req_o=0, imem_addr_o=0
  - count=0, pointers=0, inst_valid_o=0
  - pc_stall_o=1
- Queue data RAM is not reset. Reset asserted mid-fetch abandons the request; the memory side must tolerate the dropped request.

## Timing
- Issue at edge T → imem_req_o high from T+1.
- Earliest ack is in cycle T+1; the entry shows on inst_valid_o in cycle T+2.
- Next issue is possible in cycle T+2, giving a peak throughput of 1 instruction per 2 cycles with a zero-wait memory.
- A full queue (count=DEPTH) blocks issue. pc_stall_o stays 1 until a pop frees an entry; the issue happens in the cycle after that pop.
- redirect_i at T: the queue is empty at T+1. The first fetch from the target PC issues at T+1 if the FSM is IDLE, otherwise in the cycle after the discarded ack.
- Combinational paths are limited to:
  - redirect_i, state, count → pc_stall_o
  - queue head → inst_*

## Structure
- Package fetch_pkg holds:
  - state enum (IDLE/WAIT/DISCARD)
  - default DEPTH/ADDR_W/DATA_W constants
  - fetch-entry struct {pc, inst}
- Sub-module fetch_fifo holds the synchronous FIFO with flush: push, pop, flush, count, head.
- instr_fetch_unit keeps the FSM, handshake registers and stall logic.

## Test plan
- Reset, pc_i=0x0, ack one cycle after req, inst_ready_i=1 → fetches 0x0,0x4,0x8 issued every 2 cycles; inst_pc_o follows the same sequence; pc_stall_o toggles 0/1.
- inst_ready_i=0, DEPTH=2 → after two pushes, count=2, pc_stall_o stuck at 1, imem_req_o=0. Raise ready for one cycle → exactly one new issue on the following cycle.
- Memory wait of 3 cycles → imem_req_o and imem_addr_o held constant for 3 cycles; only one push per request.
- redirect_i during WAIT (ack 2 cycles later) → FSM enters DISCARD, the acked data is not pushed, the queue is empty, and the next issue uses target pc_i=0x40.
- redirect_i coincident with ack, and coincident with a pop on a full queue → no push, queue empty next cycle, count=0.
- nrst_i pulsed low asynchronously mid-WAIT → imem_req_o=0 and inst_valid_o=0 immediately. After release, fetch restarts from pc_i.
